// File: rtl/ece429_writeback.sv
// ece429_writeback: MEM/WB pipeline register, load formatting, register-file
// write port, WB bypass, retired-instruction counter and halt control.
// Data buses are big-endian: bit 0 is the MSB, byte k sits at [8k:8k+7].
module ece429_writeback (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [0:4]  mem_rd,
  input  logic        mem_rwe,
  input  logic        mem_is_load,
  input  logic [0:1]  mem_load_size,
  input  logic        mem_load_unsigned,
  input  logic [0:1]  mem_addr_lo,
  input  logic [0:31] mem_alu_result,
  input  logic [0:31] mem_load_data,
  input  logic        mem_halt,
  input  logic        wb_stall,
  output logic        mem_ready,
  output logic [0:4]  rdOut,
  output logic [0:31] rd_dataOut,
  output logic        rweOut,
  output logic        fwd_valid,
  output logic [0:4]  fwd_rd,
  output logic [0:31] fwd_data,
  output logic        halted,
  output logic        misalign_err,
  output logic [0:31] retired
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wbStateT;

  wbStateT     state;
  wbStateT     nextState;

  // MEM/WB pipeline register
  logic        wbValid;
  logic [0:4]  wbRd;
  logic        wbRwe;
  logic        wbHalt;
  logic [0:31] wbData;

  logic        misalignFlag;
  logic [0:31] retiredCount;

  // Formatted capture values
  logic [0:7]  loadByte;
  logic [0:15] loadHalf;
  logic [0:31] loadValue;
  logic        loadMisaligned;
  logic        capMisaligned;
  logic [0:31] capData;

  logic        haltPending;
  logic        inRun;
  logic        retireNow;
  logic        writeQual;

  // Load formatting and alignment check on the incoming MEM result.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    loadByte       = mem_load_data[0:7];
    loadHalf       = mem_load_data[0:15];
    loadValue      = mem_load_data;
    loadMisaligned = 1'b0;
    case (mem_addr_lo)
      2'd0:    loadByte = mem_load_data[0:7];
      2'd1:    loadByte = mem_load_data[8:15];
      2'd2:    loadByte = mem_load_data[16:23];
      default: loadByte = mem_load_data[24:31];
    endcase
    // Half selection follows address bit 1, which is addr_lo[0] in this bit order.
    if (mem_addr_lo[0]) begin
      loadHalf = mem_load_data[16:31];
    end
    case (mem_load_size)
      2'b00: begin
        loadValue = {{24{!mem_load_unsigned && loadByte[0]}}, loadByte};
      end
      2'b01: begin
        loadValue      = {{16{!mem_load_unsigned && loadHalf[0]}}, loadHalf};
        loadMisaligned = mem_addr_lo[1];
      end
      default: begin
        loadValue      = mem_load_data;
        loadMisaligned = (mem_addr_lo != 2'b00);
      end
    endcase
  end

  assign capMisaligned = mem_valid && mem_is_load && loadMisaligned;
  assign capData       = mem_is_load ? loadValue : mem_alu_result;

  assign inRun       = (state == RUN);
  assign haltPending = wbValid && wbHalt;
  assign mem_ready   = inRun && !wb_stall && !haltPending;
  assign retireNow   = wbValid && !wb_stall && inRun;

  // Next-state logic: a retiring halt entry (halt or misaligned load) stops the pipe.
  always_comb begin
    nextState = state;
    if (inRun && retireNow && wbHalt) begin
      nextState = HALTED;
    end
  end

  // State register; only reset leaves HALTED.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // MEM/WB register: reset and retiring halts clear it, a stall holds it,
  // otherwise it captures the MEM stage (a bubble when nothing is offered).
  always_ff @(posedge clock) begin
    if (reset) begin
      wbValid <= 1'b0;
      wbRd    <= '0;
      wbRwe   <= 1'b0;
      wbHalt  <= 1'b0;
      wbData  <= '0;
    end else if (wb_stall) begin
      wbValid <= wbValid;
    end else if (mem_ready) begin
      wbValid <= mem_valid;
      wbRd    <= mem_rd;
      wbRwe   <= mem_rwe && !capMisaligned;
      wbHalt  <= mem_halt || capMisaligned;
      wbData  <= capData;
    end else begin
      wbValid <= 1'b0;
      wbRd    <= '0;
      wbRwe   <= 1'b0;
      wbHalt  <= 1'b0;
      wbData  <= '0;
    end
  end

  // Sticky misalignment flag, set when a misaligned load is captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      misalignFlag <= 1'b0;
    end else if (mem_ready && capMisaligned) begin
      misalignFlag <= 1'b1;
    end
  end

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      retiredCount <= '0;
    end else if (retireNow) begin
      retiredCount <= retiredCount + 32'd1;
    end
  end

  // Write port and bypass share one qualification; r0 is never written.
  assign writeQual    = wbValid && wbRwe && (wbRd != 5'd0) && inRun;
  assign rdOut        = wbRd;
  assign rd_dataOut   = wbData;
  assign rweOut       = writeQual;
  assign fwd_valid    = writeQual;
  assign fwd_rd       = wbRd;
  assign fwd_data     = wbData;
  assign halted       = (state == HALTED);
  assign misalign_err = misalignFlag;
  assign retired      = retiredCount;

endmodule

// File: tb/tb_ece429_writeback.sv
// Directed bench for ece429_writeback with a write-port scoreboard.
module tb_ece429_writeback;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic [0:4]  mem_rd;
  logic        mem_rwe;
  logic        mem_is_load;
  logic [0:1]  mem_load_size;
  logic        mem_load_unsigned;
  logic [0:1]  mem_addr_lo;
  logic [0:31] mem_alu_result;
  logic [0:31] mem_load_data;
  logic        mem_halt;
  logic        wb_stall;
  logic        mem_ready;
  logic [0:4]  rdOut;
  logic [0:31] rd_dataOut;
  logic        rweOut;
  logic        fwd_valid;
  logic [0:4]  fwd_rd;
  logic [0:31] fwd_data;
  logic        halted;
  logic        misalign_err;
  logic [0:31] retired;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rwe;
  } wbExpT;

  wbExpT sbQueue[$];
  int    passCount  = 0;
  int    totalCount = 0;
  int    expRetired = 0;

  localparam logic [31:0] LDATA = 32'h80FF7F01;

  ece429_writeback dut (
    .clock             (clock),
    .reset             (reset),
    .mem_valid         (mem_valid),
    .mem_rd            (mem_rd),
    .mem_rwe           (mem_rwe),
    .mem_is_load       (mem_is_load),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_addr_lo       (mem_addr_lo),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_halt          (mem_halt),
    .wb_stall          (wb_stall),
    .mem_ready         (mem_ready),
    .rdOut             (rdOut),
    .rd_dataOut        (rd_dataOut),
    .rweOut            (rweOut),
    .fwd_valid         (fwd_valid),
    .fwd_rd            (fwd_rd),
    .fwd_data          (fwd_data),
    .halted            (halted),
    .misalign_err      (misalign_err),
    .retired           (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one posedge and settle before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mem_valid         = 1'b0;
    mem_rd            = '0;
    mem_rwe           = 1'b0;
    mem_is_load       = 1'b0;
    mem_load_size     = 2'b00;
    mem_load_unsigned = 1'b0;
    mem_addr_lo       = 2'b00;
    mem_alu_result    = '0;
    mem_load_data     = '0;
    mem_halt          = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expRetired = 0;
  endtask

  // Pop one expected write and compare it with the write port and bypass.
  task automatic checkWrite(input string tag);
    wbExpT e;
    totalCount++;
    assert (sbQueue.size() > 0) passCount++;
    else $error("FAIL %s_sb observed=empty expected=entry", tag);
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      check({tag, "_rwe"}, {31'd0, rweOut}, {31'd0, e.rwe});
      check({tag, "_fwdv"}, {31'd0, fwd_valid}, {31'd0, e.rwe});
      if (e.rwe) begin
        check({tag, "_rd"}, {27'd0, rdOut}, {27'd0, e.rd});
        check({tag, "_data"}, rd_dataOut, e.data);
        check({tag, "_fwdd"}, fwd_data, e.data);
      end
    end
  endtask

  // Present one instruction, push its expected write, capture it, and check.
  task automatic issue(input string tag, input logic [4:0] rd, input logic isLoad,
                       input logic [1:0] size, input logic uns, input logic [1:0] addr,
                       input logic [31:0] value, input logic [31:0] expData);
    mem_valid         = 1'b1;
    mem_rd            = rd;
    mem_rwe           = 1'b1;
    mem_is_load       = isLoad;
    mem_load_size     = size;
    mem_load_unsigned = uns;
    mem_addr_lo       = addr;
    mem_alu_result    = isLoad ? 32'h0 : value;
    mem_load_data     = isLoad ? value : 32'h0;
    mem_halt          = 1'b0;
    sbQueue.push_back('{rd, expData, rd != 5'd0});
    tick();
    idle();
    checkWrite(tag);
    check({tag, "_retired"}, retired, expRetired);
    expRetired++;
  endtask

  initial begin
    wb_stall = 1'b0;
    idle();
    reset = 1'b1;
    tick();
    doReset();

    // Reset state
    check("rst_rwe", {31'd0, rweOut}, 32'd0);
    check("rst_fwdv", {31'd0, fwd_valid}, 32'd0);
    check("rst_rd", {27'd0, rdOut}, 32'd0);
    check("rst_data", rd_dataOut, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_retired", retired, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // ALU write and load formatting
    issue("alu", 5'd5, 1'b0, 2'b00, 1'b0, 2'd0, 32'h12345678, 32'h12345678);
    issue("lb0", 5'd10, 1'b1, 2'b00, 1'b0, 2'd0, LDATA, 32'hFFFFFF80);
    issue("lbu0", 5'd11, 1'b1, 2'b00, 1'b1, 2'd0, LDATA, 32'h00000080);
    issue("lb2", 5'd12, 1'b1, 2'b00, 1'b0, 2'd2, LDATA, 32'h0000007F);
    issue("lbu3", 5'd13, 1'b1, 2'b00, 1'b1, 2'd3, LDATA, 32'h00000001);
    issue("lh2", 5'd14, 1'b1, 2'b01, 1'b0, 2'd2, LDATA, 32'h00007F01);
    issue("lhu0", 5'd15, 1'b1, 2'b01, 1'b1, 2'd0, LDATA, 32'h000080FF);
    issue("lh0", 5'd16, 1'b1, 2'b01, 1'b0, 2'd0, LDATA, 32'hFFFF80FF);
    issue("lw0", 5'd17, 1'b1, 2'b10, 1'b0, 2'd0, LDATA, LDATA);
    issue("r0", 5'd0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000DEAD, 32'h0000DEAD);
    tick();
    check("r0_counted", retired, expRetired);
    check("no_misalign", {31'd0, misalign_err}, 32'd0);

    // Stall: rd 7 held three cycles, counted once; rd 8 waits upstream.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_rwe = 1'b1; mem_alu_result = 32'hCAFE0007;
    tick();
    wb_stall = 1'b1;
    mem_rd = 5'd8; mem_alu_result = 32'hCAFE0008;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", {31'd0, mem_ready}, 32'd0);
      check("stall_rwe", {31'd0, rweOut}, 32'd1);
      check("stall_rd", {27'd0, rdOut}, 32'd7);
      check("stall_data", rd_dataOut, 32'hCAFE0007);
      check("stall_retired", retired, expRetired);
      tick();
    end
    idle();
    wb_stall = 1'b0;
    tick();
    expRetired++;
    check("stall_retire_once", retired, expRetired);
    check("stall_drained", {31'd0, rweOut}, 32'd0);

    // Halt followed by a write to r9
    mem_valid = 1'b1; mem_halt = 1'b1;
    tick();
    mem_halt = 1'b0; mem_rd = 5'd9; mem_rwe = 1'b1; mem_alu_result = 32'h99999999;
    check("halt_pend_ready", {31'd0, mem_ready}, 32'd0);
    check("halt_pend_halted", {31'd0, halted}, 32'd0);
    tick();
    expRetired++;
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_retired", retired, expRetired);
    for (int i = 0; i < 3; i++) begin
      check("halt_no_r9", {31'd0, rweOut}, 32'd0);
      check("halt_fwdv", {31'd0, fwd_valid}, 32'd0);
      check("halt_ready", {31'd0, mem_ready}, 32'd0);
      check("halt_frozen", retired, expRetired);
      tick();
    end
    idle();
    doReset();
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_ready", {31'd0, mem_ready}, 32'd1);

    // Misaligned word load
    mem_valid = 1'b1; mem_rd = 5'd11; mem_rwe = 1'b1; mem_is_load = 1'b1;
    mem_load_size = 2'b10; mem_addr_lo = 2'd2; mem_load_data = LDATA;
    tick();
    idle();
    check("mis_rwe", {31'd0, rweOut}, 32'd0);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_halted_early", {31'd0, halted}, 32'd0);
    tick();
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_retired", retired, 32'd1);
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);
    doReset();
    check("mis_rst_err", {31'd0, misalign_err}, 32'd0);
    check("mis_rst_halted", {31'd0, halted}, 32'd0);
    check("mis_rst_retired", retired, 32'd0);

    // Misaligned half load (address bit 0 set)
    mem_valid = 1'b1; mem_rd = 5'd12; mem_rwe = 1'b1; mem_is_load = 1'b1;
    mem_load_size = 2'b01; mem_addr_lo = 2'd1; mem_load_data = LDATA;
    tick();
    idle();
    check("mish_rwe", {31'd0, rweOut}, 32'd0);
    check("mish_err", {31'd0, misalign_err}, 32'd1);
    doReset();

    // Counter wrap
    dut.retiredCount = 32'hFFFFFFFF;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_rwe = 1'b1; mem_alu_result = 32'h1;
    tick();
    idle();
    check("wrap_pre", retired, 32'hFFFFFFFF);
    tick();
    check("wrap", retired, 32'd0);

    // Reset during a stalled valid entry
    mem_valid = 1'b1; mem_rd = 5'd4; mem_rwe = 1'b1; mem_alu_result = 32'h44;
    tick();
    idle();
    wb_stall = 1'b1;
    check("rst_stall_pre", {31'd0, rweOut}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_stall_rwe", {31'd0, rweOut}, 32'd0);
    check("rst_stall_retired", retired, 32'd0);
    check("rst_stall_rd", {27'd0, rdOut}, 32'd0);
    wb_stall = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/ece429_writeback.md
# ece429_writeback

Writeback stage of the ECE429 five-stage MIPS pipeline: captures the MEM-stage result into the MEM/WB pipeline register, formats load data, and drives the register-file write port (`rdOut`, `rd_dataOut`, `rweOut`). The register file commits these on the falling edge of the same cycle. The block also drives a WB bypass result for the decode stage, counts retired instructions, and halts the pipeline on a halt instruction or a misaligned load. All data buses use big-endian bit order: `[0:31]`, with bit 0 as the MSB and byte k at bits `[8k:8k+7]`.

## Interface
- No parameters.
- `clock` in 1: pipeline clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: MEM stage presents an instruction.
- `mem_rd` in [0:4]: destination register.
- `mem_rwe` in 1: instruction writes a register.
- `mem_is_load` in 1: result comes from `mem_load_data`; otherwise from `mem_alu_result`.
- `mem_load_size` in [0:1]: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `mem_load_unsigned` in 1: zero-extend; otherwise sign-extend.
- `mem_addr_lo` in [0:1]: effective address bits [1:0].
- `mem_alu_result` in [0:31]: ALU/link result.
- `mem_load_data` in [0:31]: aligned word read from data memory.
- `mem_halt` in 1: instruction is a halt (syscall/break).
- `wb_stall` in 1: hold the WB register.
- `mem_ready` out 1: WB accepts a new instruction this cycle.
- `rdOut` out [0:4]: register-file write address.
- `rd_dataOut` out [0:31]: register-file write data.
- `rweOut` out 1: register-file write enable.
- `fwd_valid` out 1: bypass data is valid.
- `fwd_rd` out [0:4]: bypass destination register.
- `fwd_data` out [0:31]: bypass data.
- `halted` out 1: block is in the HALTED state.
- `misalign_err` out 1: sticky flag, set by a misaligned load.
- `retired` out [0:31]: count of retired instructions.

## Operation
- **States:** RUN and HALTED. Reset enters RUN. Only reset leaves HALTED.
- **`mem_ready`:** equals `(state == RUN) && !wb_stall && !halt_pending`.
- **Capture:** on posedge with `mem_ready`, the WB register loads `mem_valid` plus the formatted result, rd, rwe and halt. With `!wb_stall` but `mem_valid = 0`, it loads a bubble (valid = 0).
- **Stall:** with `wb_stall`, the WB register holds unchanged.
- **Load formatting (combinational, before the register):**
  - Byte: select byte `mem_addr_lo` (0 gives bits [0:7]), then extend to 32 bits.
  - Half: `addr_lo[0] = 0` selects bits [0:15]; `addr_lo[0] = 1` selects bits [16:31]. The selection is on the `addr_lo` bit, not the value, then extend.
  - Word: pass through unchanged.
- **Misalignment:**
  - A half load is misaligned when `addr_lo[1]` = 1.
  - A word load is misaligned when `addr_lo` != 0.
  - On capture of a misaligned load: store valid = 1, rwe = 0, and halt = 1. `misalign_err` sets on the same posedge and stays set until reset.
- **Write port:**
  - `rdOut` = WB rd.
  - `rd_dataOut` = WB data.
  - `rweOut = wb_valid && wb_rwe && (wb_rd != 0) && (state == RUN)`.
  - Writes to r0 are never asserted.
- **Bypass:** `fwd_valid`, `fwd_rd` and `fwd_data` mirror the write-port qualification (`fwd_valid == rweOut`).
- **Retire:** `retired` increments by 1 on each posedge where `wb_valid && !wb_stall && state == RUN`. This includes halt and misaligned entries and excludes bubbles. It wraps from 0xFFFFFFFF to 0.
- **Halt:**
  - `halt_pending` is the WB register's halt bit while `wb_valid`.
  - When a halt entry retires, the state becomes HALTED on that posedge and the WB register clears to a bubble.
  - In HALTED: `mem_ready` = 0, `rweOut` = 0, `fwd_valid` = 0, and `retired` is frozen.

## Timing
- **Latency:** one cycle. An instruction accepted at posedge N drives the write port during cycle N..N+1, and the register file commits it at the negedge in between.
- **Stall:** an entry held by `wb_stall` keeps `rweOut` asserted. The repeated write of the same value is idempotent and is not re-counted.
- **Reset (synchronous, checked on posedge):**
  - WB register becomes a bubble.
  - State becomes RUN.
  - `retired` = 0 and `misalign_err` = 0.
  - Outputs after reset: `rweOut` = 0, `fwd_valid` = 0, `rdOut` = 0, `rd_dataOut` = 0, `halted` = 0, `mem_ready` = 1.
- **Reset mid-operation:** reset overrides stall, halt and capture in the same cycle. The in-flight entry is discarded and not counted.
- **Halt entry in WB:** `mem_ready` = 0 while a halt entry sits in WB, so nothing behind it is accepted.
- **Simultaneous halt and stall:** the transition to HALTED waits until the stall drops.

## Test plan
- **ALU write:** reset, then `mem_valid` = 1, rd = 5, rwe = 1, ALU = 0x12345678 → next cycle `rweOut` = 1, `rdOut` = 5, `rd_dataOut` = 0x12345678, `fwd_valid` = 1; `retired` = 1 after the following posedge.
- **Loads:** `load_data` = 0x80FF7F01.
  - lb with `addr_lo` = 0 → 0xFFFFFF80.
  - lbu with `addr_lo` = 0 → 0x00000080.
  - lb with `addr_lo` = 2 → 0x0000007F.
  - lh with `addr_lo` = 2 → 0x00007F01.
  - lhu with `addr_lo` = 0 → 0x000080FF.
- **r0 and stall:** rd = 0, rwe = 1 → `rweOut` = 0 and the instruction still counts. `wb_stall` held 3 cycles with rd = 7 valid → `rweOut` stays 1, `mem_ready` = 0, `retired` increments once.
- **Halt:** halt followed by a valid write to r9 → r9 is never written, `halted` = 1, `retired` includes the halt, `mem_ready` stays 0.
- **Misaligned load:** lw with `addr_lo` = 2 → `rweOut` = 0, `misalign_err` = 1, `halted` = 1 one cycle later. Reset then clears all flags and `retired` = 0.
- **Wrap and reset:** force `retired` to 0xFFFFFFFF and retire one instruction → `retired` = 0. Assert reset during a stalled valid entry → `rweOut` = 0 next cycle.
